clock_monitor: RTL and testbench
================================

Name: clock_monitor

Overview:
- Checks a free-running clock generated elsewhere in the design (`mon_clk`). Measures it against the local reference clock.
- Samples `mon_clk` through a synchronizer.
- Measures period and high time in reference cycles, and checks both against expected windows.
- Reports lock, period/duty violations and loss of clock. Sits beside the clock generators as the on-chip checker.

Parameters:
- CNT_W, 16, width of period/high counters and outputs
- EXP_PERIOD, 8, expected mon_clk period in clk cycles
- PER_TOL, 1, allowed |period − EXP_PERIOD| in clk cycles (jitter budget)
- DUTY_MIN, 20, minimum high time in percent
- DUTY_MAX, 30, maximum high time in percent
- TIMEOUT, 64, clk cycles without a rising edge before loss is declared
- LOCK_CNT, 4, consecutive error-free measurements required for lock

Ports:
- clk  input  1  reference clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  monitor enable (synchronous to clk)
- mon_clk  input  1  monitored clock, asynchronous to clk
- meas_valid  output  1  one-cycle pulse when a new measurement is available
- meas_period  output  CNT_W  last measured period, in clk cycles
- meas_high  output  CNT_W  last measured high time, in clk cycles
- period_err  output  1  last period outside the tolerance window
- duty_err  output  1  last duty cycle outside [DUTY_MIN, DUTY_MAX]
- locked  output  1  LOCK_CNT consecutive good measurements seen
- lost  output  1  no rising edge for TIMEOUT cycles

Behaviour:
- Reset/clock: one clock (`clk`); `rst_n` is asynchronous and active-low. On reset, every output and internal register is 0 and the state is IDLE.
- Synchronizer: two flops s1, s2, plus edge flop s3. rise = s2 & ~s3. A mon_clk rising edge is seen 2–3 clk cycles later.
- State IDLE: counters held at 0. If en=1, go to ACQUIRE.
- State ACQUIRE: on rise, per_cnt and high_cnt are set to 1 and the state goes to MEASURE. No meas_valid is produced, because there is no prior edge.
- State MEASURE, non-rise cycle:
  - per_cnt increments; high_cnt increments if s2=1.
  - Both counters saturate at all-ones.
- State MEASURE, rise cycle:
  - meas_period ← per_cnt and meas_high ← high_cnt.
  - meas_valid=1 in the following cycle, with the errors registered in that same cycle.
  - Both counters reload to 1.
  - Example: rise every 8 cycles → meas_period=8.
- period_err: set when meas_period < EXP_PERIOD−PER_TOL or meas_period > EXP_PERIOD+PER_TOL. Unsigned compares; the lower bound clamps at 0.
- duty_err: set when meas_high·100 < DUTY_MIN·meas_period or meas_high·100 > DUTY_MAX·meas_period. Products are computed at CNT_W+7 bits with no overflow.
- Error hold: both error flags update only with meas_valid and hold until the next measurement.
- Lock counter:
  - good_cnt increments on each meas_valid with no error, saturating at LOCK_CNT. locked=1 when good_cnt==LOCK_CNT.
  - Any measurement with an error clears good_cnt and locked in the same cycle the error is flagged.
- Timeout: in MEASURE, if per_cnt reaches TIMEOUT with no rise, go to LOST.
- State LOST:
  - lost=1, locked=0, good_cnt=0; meas_* and the error flags are held.
  - On rise: lost→0, counters reload to 1, go to MEASURE. The first post-loss measurement is valid.
- en=0 in any state: next cycle go to IDLE. Clears counters, good_cnt, locked, lost, the error flags and meas_valid. meas_period/meas_high keep their last values.
- Reset mid-measurement: immediate clear and return to IDLE; there is no partial measurement.
- Simultaneous rise and timeout threshold in the same cycle: rise wins, so the measurement is taken and there is no LOST.

Optional Feature:
- Macro: `CLKMON_HIST_EN`.
- When defined:
  - Adds outputs per_min and per_max (each CNT_W bits).
  - On each meas_valid they update to the min/max of all periods since en rose.
  - On en=0 or reset, per_min=all-ones and per_max=0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- 100 MHz clk, mon_clk period 80 ns, 25% duty, en=1 → meas_valid every 8 cycles with meas_period=8, meas_high=2, no errors; locked=1 after the 4th meas_valid.
- Once locked, stretch one mon_clk period to 120 ns → that measurement reads meas_period=12, period_err=1, locked=0. Re-lock after 4 further good periods.
- mon_clk at 50% duty (period 80 ns) → meas_high=4, duty_err=1 on every measurement, locked never set.
- Stop mon_clk while locked → lost=1 and locked=0 exactly when per_cnt reaches 64. Restart mon_clk → lost clears on the first rise; the next measurement is valid.
- Assert rst_n=0 mid-period, then en=0 for one cycle mid-period → outputs clear as specified; the first rise after re-enable produces no meas_valid (ACQUIRE).
- With `CLKMON_HIST_EN`: periods 8, 7, 9, 8 → per_min=7, per_max=9.

Source files
------------

// File: rtl/clock_monitor_if.sv
// Port bundle for clock_monitor: enable and monitored clock in, measurement
// results and status flags out. The optional period history outputs exist
// only when CLKMON_HIST_EN is defined.
interface clock_monitor_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             mon_clk;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             period_err;
    logic             duty_err;
    logic             locked;
    logic             lost;
`ifdef CLKMON_HIST_EN
    logic [CNT_W-1:0] per_min;
    logic [CNT_W-1:0] per_max;

    modport master (
        output en, mon_clk,
        input  meas_valid, meas_period, meas_high, period_err, duty_err,
               locked, lost, per_min, per_max
    );
    modport slave (
        input  en, mon_clk,
        output meas_valid, meas_period, meas_high, period_err, duty_err,
               locked, lost, per_min, per_max
    );
`else
    modport master (
        output en, mon_clk,
        input  meas_valid, meas_period, meas_high, period_err, duty_err,
               locked, lost
    );
    modport slave (
        input  en, mon_clk,
        output meas_valid, meas_period, meas_high, period_err, duty_err,
               locked, lost
    );
`endif
endinterface

// File: rtl/clock_monitor.sv
// clock_monitor: measures period and high time of an asynchronous clock
// (mon_clk) in clk cycles, checks them against expected windows and reports
// lock and loss of clock.
// Optional feature macro: CLKMON_HIST_EN adds per_min/per_max period history.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | disabled, counters held at 0
// ACQUIRE | enabled, waiting for the first rising edge (no prior edge)
// MEASURE | counting period/high time between rising edges
// LOST    | no rising edge for TIMEOUT cycles; results held
module clock_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 8,
    parameter int PER_TOL    = 1,
    parameter int DUTY_MIN   = 20,
    parameter int DUTY_MAX   = 30,
    parameter int TIMEOUT    = 64,
    parameter int LOCK_CNT   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    clock_monitor_if.slave mif
);

    localparam int PW     = CNT_W + 7;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    // Lower bound clamps at zero when the tolerance exceeds the nominal period
    localparam logic [CNT_W-1:0] PER_LO =
        (EXP_PERIOD > PER_TOL) ? CNT_W'(EXP_PERIOD - PER_TOL) : '0;
    localparam logic [CNT_W-1:0]  PER_HI   = CNT_W'(EXP_PERIOD + PER_TOL);
    localparam logic [CNT_W-1:0]  TMO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);
    localparam logic [PW-1:0]     K100     = PW'(100);
    localparam logic [PW-1:0]     KMIN     = PW'(DUTY_MIN);
    localparam logic [PW-1:0]     KMAX     = PW'(DUTY_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2,
        LOST    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic s1_q, s2_q, s3_q;
    logic rise;
    logic capture;

    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]  meas_period_q, meas_period_d;
    logic [CNT_W-1:0]  meas_high_q, meas_high_d;
    logic              meas_valid_q, meas_valid_d;
    logic              period_err_q, period_err_d;
    logic              duty_err_q, duty_err_d;
    logic              locked_q, locked_d;
    logic              lost_q, lost_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;

    logic [CNT_W-1:0]  per_inc, high_inc;
    logic [GOOD_W-1:0] good_inc;
    logic [PW-1:0]     high_x100, duty_lo_lim, duty_hi_lim;
    logic              per_err_now, duty_err_now;

    // Two-flop synchronizer for mon_clk plus an edge-detect flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= mif.mon_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise    = s2_q & ~s3_q;
    assign capture = mif.en && (state_q == MEASURE) && rise;

    assign per_inc  = (&per_cnt_q)  ? per_cnt_q  : per_cnt_q + CNT_ONE;
    assign high_inc = (&high_cnt_q) ? high_cnt_q : high_cnt_q + CNT_ONE;
    assign good_inc = (good_cnt_q == GOOD_MAX) ? good_cnt_q : good_cnt_q + GOOD_ONE;

    // Errors are judged on the counts about to be captured, so the flags
    // appear in the same cycle as meas_valid.
    assign high_x100    = PW'(high_cnt_q) * K100;
    assign duty_lo_lim  = PW'(per_cnt_q) * KMIN;
    assign duty_hi_lim  = PW'(per_cnt_q) * KMAX;
    assign per_err_now  = (per_cnt_q < PER_LO) || (per_cnt_q > PER_HI);
    assign duty_err_now = (high_x100 < duty_lo_lim) || (high_x100 > duty_hi_lim);

    // Next-state and result logic; disable overrides every state
    always_comb begin
        state_d       = state_q;
        per_cnt_d     = per_cnt_q;
        high_cnt_d    = high_cnt_q;
        meas_period_d = meas_period_q;
        meas_high_d   = meas_high_q;
        meas_valid_d  = 1'b0;
        period_err_d  = period_err_q;
        duty_err_d    = duty_err_q;
        locked_d      = locked_q;
        lost_d        = lost_q;
        good_cnt_d    = good_cnt_q;

        if (!mif.en) begin
            state_d      = IDLE;
            per_cnt_d    = '0;
            high_cnt_d   = '0;
            period_err_d = 1'b0;
            duty_err_d   = 1'b0;
            locked_d     = 1'b0;
            lost_d       = 1'b0;
            good_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    per_cnt_d  = '0;
                    high_cnt_d = '0;
                    state_d    = ACQUIRE;
                end
                ACQUIRE: begin
                    if (rise) begin
                        per_cnt_d  = CNT_ONE;
                        high_cnt_d = CNT_ONE;
                        state_d    = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // A rise on the timeout cycle still counts as a measurement
                        meas_period_d = per_cnt_q;
                        meas_high_d   = high_cnt_q;
                        meas_valid_d  = 1'b1;
                        period_err_d  = per_err_now;
                        duty_err_d    = duty_err_now;
                        if (per_err_now || duty_err_now) begin
                            good_cnt_d = '0;
                            locked_d   = 1'b0;
                        end else begin
                            good_cnt_d = good_inc;
                            locked_d   = (good_inc == GOOD_MAX);
                        end
                        per_cnt_d  = CNT_ONE;
                        high_cnt_d = CNT_ONE;
                    end else if (per_cnt_q >= TMO) begin
                        state_d    = LOST;
                        lost_d     = 1'b1;
                        locked_d   = 1'b0;
                        good_cnt_d = '0;
                    end else begin
                        per_cnt_d = per_inc;
                        if (s2_q) begin
                            high_cnt_d = high_inc;
                        end
                    end
                end
                LOST: begin
                    if (rise) begin
                        lost_d     = 1'b0;
                        per_cnt_d  = CNT_ONE;
                        high_cnt_d = CNT_ONE;
                        state_d    = MEASURE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            per_cnt_q     <= '0;
            high_cnt_q    <= '0;
            meas_period_q <= '0;
            meas_high_q   <= '0;
            meas_valid_q  <= 1'b0;
            period_err_q  <= 1'b0;
            duty_err_q    <= 1'b0;
            locked_q      <= 1'b0;
            lost_q        <= 1'b0;
            good_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            high_cnt_q    <= high_cnt_d;
            meas_period_q <= meas_period_d;
            meas_high_q   <= meas_high_d;
            meas_valid_q  <= meas_valid_d;
            period_err_q  <= period_err_d;
            duty_err_q    <= duty_err_d;
            locked_q      <= locked_d;
            lost_q        <= lost_d;
            good_cnt_q    <= good_cnt_d;
        end
    end

    assign mif.meas_valid  = meas_valid_q;
    assign mif.meas_period = meas_period_q;
    assign mif.meas_high   = meas_high_q;
    assign mif.period_err  = period_err_q;
    assign mif.duty_err    = duty_err_q;
    assign mif.locked      = locked_q;
    assign mif.lost        = lost_q;

`ifdef CLKMON_HIST_EN
    logic [CNT_W-1:0] per_min_q, per_min_d;
    logic [CNT_W-1:0] per_max_q, per_max_d;

    // Running min/max of captured periods since enable rose
    always_comb begin
        per_min_d = per_min_q;
        per_max_d = per_max_q;
        if (!mif.en) begin
            per_min_d = '1;
            per_max_d = '0;
        end else if (capture) begin
            if (per_cnt_q < per_min_q) per_min_d = per_cnt_q;
            if (per_cnt_q > per_max_q) per_max_d = per_cnt_q;
        end
    end

    // History registers; min starts at all-ones so the first capture wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_min_q <= '1;
            per_max_q <= '0;
        end else begin
            per_min_q <= per_min_d;
            per_max_q <= per_max_d;
        end
    end

    assign mif.per_min = per_min_q;
    assign mif.per_max = per_max_q;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor. mon_clk is built from pulses of a
// whole number of clk cycles; a reference model predicts every measurement
// from pulse timing alone (gap between rises, time spent high).
module tb_clock_monitor;

    localparam int CNT_W      = 16;
    localparam int EXP_PERIOD = 8;
    localparam int PER_TOL    = 1;
    localparam int DUTY_MIN   = 20;
    localparam int DUTY_MAX   = 30;
    localparam int TIMEOUT    = 64;
    localparam int LOCK_CNT   = 4;
    localparam int ALL_ONES   = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    clock_monitor_if #(.CNT_W(CNT_W)) mif ();

    clock_monitor #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .PER_TOL(PER_TOL),
        .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX), .TIMEOUT(TIMEOUT),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mif  (mif.slave)
    );

    typedef struct {
        int p;
        int h;
        bit pe;
        bit de;
        bit lk;
        int mn;
        int mx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pushed = 0;
    int n_seen   = 0;
    int cyc      = 0;

    bit m_en        = 1'b0;
    bit m_have_prev = 1'b0;
    int m_last_rise = 0;
    int m_last_high = 0;
    int m_good      = 0;
    int m_min       = ALL_ONES;
    int m_max       = 0;
    int m_last_per  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model_clear();
        m_have_prev = 1'b0;
        m_good      = 0;
        m_min       = ALL_ONES;
        m_max       = 0;
    endfunction

    // Called on the cycle mon_clk is driven high
    function automatic void model_rise();
        int   gap;
        exp_t e;
        if (!m_en) return;
        gap = cyc - m_last_rise;
        if (m_have_prev && gap <= TIMEOUT) begin
            e.p  = gap;
            e.h  = m_last_high;
            e.pe = (gap < EXP_PERIOD - PER_TOL) || (gap > EXP_PERIOD + PER_TOL);
            e.de = (m_last_high * 100 < DUTY_MIN * gap) || (m_last_high * 100 > DUTY_MAX * gap);
            if (e.pe || e.de) m_good = 0;
            else if (m_good < LOCK_CNT) m_good++;
            e.lk = (m_good == LOCK_CNT);
            if (gap < m_min) m_min = gap;
            if (gap > m_max) m_max = gap;
            e.mn = m_min;
            e.mx = m_max;
            m_last_per = gap;
            exp_q.push_back(e);
            n_pushed++;
        end else if (m_have_prev) begin
            m_good = 0;
        end
        m_have_prev = 1'b1;
        m_last_rise = cyc;
    endfunction

    function automatic void model_fall();
        m_last_high = cyc - m_last_rise;
    endfunction

    task automatic mon_pulse(input int h, input int l);
        model_rise();
        mif.mon_clk = 1'b1;
        repeat (h) @(negedge clk);
        model_fall();
        mif.mon_clk = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    // Every meas_valid must match the next predicted measurement
    always @(negedge clk) begin
        if (rst_n && mif.meas_valid === 1'b1) begin
            n_seen++;
            chk("meas_valid_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("meas_period", mif.meas_period, mon_e.p);
                chk("meas_high", mif.meas_high, mon_e.h);
                chk("period_err", mif.period_err, mon_e.pe);
                chk("duty_err", mif.duty_err, mon_e.de);
                chk("locked_at_meas", mif.locked, mon_e.lk);
`ifdef CLKMON_HIST_EN
                chk("per_min", mif.per_min, mon_e.mn);
                chk("per_max", mif.per_max, mon_e.mx);
`endif
            end
        end
    end

    initial begin
        int cnt;
        mif.en      = 1'b0;
        mif.mon_clk = 1'b0;
        model_clear();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_meas_valid", mif.meas_valid, 0);
        chk("rst_meas_period", mif.meas_period, 0);
        chk("rst_meas_high", mif.meas_high, 0);
        chk("rst_period_err", mif.period_err, 0);
        chk("rst_duty_err", mif.duty_err, 0);
        chk("rst_locked", mif.locked, 0);
        chk("rst_lost", mif.lost, 0);
`ifdef CLKMON_HIST_EN
        chk("rst_per_min", mif.per_min, ALL_ONES);
        chk("rst_per_max", mif.per_max, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        mif.en = 1'b1;
        m_en   = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal 80 ns / 25% duty
        repeat (6) mon_pulse(2, 6);
        chk("nominal_locked", mif.locked, 1);
        chk("nominal_period", mif.meas_period, 8);
        chk("nominal_high", mif.meas_high, 2);

        // One stretched 120 ns period, then re-lock
        mon_pulse(2, 10);
        mon_pulse(2, 6);
        chk("stretch_period", mif.meas_period, 12);
        chk("stretch_period_err", mif.period_err, 1);
        chk("stretch_locked", mif.locked, 0);
        repeat (4) mon_pulse(2, 6);
        chk("relock_locked", mif.locked, 1);

        // 50% duty
        repeat (6) mon_pulse(4, 4);
        chk("duty50_high", mif.meas_high, 4);
        chk("duty50_duty_err", mif.duty_err, 1);
        chk("duty50_locked", mif.locked, 0);

        // Random pulse shapes
        for (int i = 0; i < 40; i++) begin
            mon_pulse(int'($urandom_range(1, 5)), int'($urandom_range(2, 8)));
        end

        // Rise exactly on the timeout cycle is measured, not lost
        mon_pulse(2, 62);
        mon_pulse(2, 6);
        chk("tmo_edge_lost", mif.lost, 0);
        chk("tmo_edge_period", mif.meas_period, 64);
        chk("tmo_edge_period_err", mif.period_err, 1);

        // Loss of clock while locked
        repeat (5) mon_pulse(2, 6);
        chk("preloss_locked", mif.locked, 1);
        model_rise();
        mif.mon_clk = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 2) begin
                model_fall();
                mif.mon_clk = 1'b0;
            end
        end while (mif.lost !== 1'b1 && cnt < 200);
        chk("loss_delay", cnt, TIMEOUT + 3);
        chk("loss_lost", mif.lost, 1);
        chk("loss_locked", mif.locked, 0);
        chk("loss_period_held", mif.meas_period, 8);
        repeat (20) @(negedge clk);
        chk("loss_lost_held", mif.lost, 1);
        mon_pulse(2, 6);
        chk("restart_lost", mif.lost, 0);
        repeat (5) mon_pulse(2, 6);

        // Enable dropped for one cycle mid-period
        model_rise();
        mif.mon_clk = 1'b1;
        repeat (2) @(negedge clk);
        model_fall();
        mif.mon_clk = 1'b0;
        repeat (3) @(negedge clk);
        mif.en = 1'b0;
        m_en   = 1'b0;
        model_clear();
        @(negedge clk);
        chk("endrop_locked", mif.locked, 0);
        chk("endrop_lost", mif.lost, 0);
        chk("endrop_period_err", mif.period_err, 0);
        chk("endrop_duty_err", mif.duty_err, 0);
        chk("endrop_meas_valid", mif.meas_valid, 0);
        chk("endrop_period_held", mif.meas_period, m_last_per);
`ifdef CLKMON_HIST_EN
        chk("endrop_per_min", mif.per_min, ALL_ONES);
        chk("endrop_per_max", mif.per_max, 0);
`endif
        mif.en = 1'b1;
        m_en   = 1'b1;
        repeat (3) @(negedge clk);
        // First rise is acquisition only; then periods 8, 7, 9, 8
        mon_pulse(2, 6);
        mon_pulse(2, 5);
        mon_pulse(2, 7);
        mon_pulse(2, 6);
        mon_pulse(2, 6);
        chk("reen_locked", mif.locked, 1);
`ifdef CLKMON_HIST_EN
        chk("hist_per_min", mif.per_min, 7);
        chk("hist_per_max", mif.per_max, 9);
`endif

        // Reset asserted mid-period
        model_rise();
        mif.mon_clk = 1'b1;
        repeat (2) @(negedge clk);
        model_fall();
        mif.mon_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        m_en  = 1'b0;
        model_clear();
        #1;
        chk("midrst_meas_period", mif.meas_period, 0);
        chk("midrst_meas_high", mif.meas_high, 0);
        chk("midrst_locked", mif.locked, 0);
        chk("midrst_meas_valid", mif.meas_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_en  = 1'b1;
        repeat (3) @(negedge clk);
        repeat (6) mon_pulse(2, 6);
        chk("postrst_locked", mif.locked, 1);

        // Drain and confirm every predicted measurement appeared
        repeat (10) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("meas_count", n_seen, n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
